lcm_gcd_seq: RTL and testbench

- Parametrised, handshaked successor to the fixed 16-bit LCM unit.
- Computes LCM or GCD of two unsigned WIDTH-bit operands with an iterative add/subtract datapath, one step per clock.
- Sits in the lab7 arithmetic library as a multi-cycle coprocessor block: start/busy/done handshake, result held until the next operation.
- Adds the behaviour the old block lacks: mode select, overflow detection, zero-operand handling and reset.

---
 rtl/lcm_gcd_seq_if.sv | 52 +++++
 rtl/lcm_gcd_seq.sv | 150 +++++++++++++++
 tb/tb_lcm_gcd_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcm_gcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : lcm_gcd_seq_if
// Brief    : start/busy/done handshake bundle for the LCM/GCD coprocessor.
//            The cycle_cnt signal exists only with LCM_CYCLE_CNT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface lcm_gcd_seq_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) ();

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [WIDTH-1:0] LCM_out;

    // Rejects degenerate configurations at elaboration time.
    if (WIDTH < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("lcm_gcd_seq_if: WIDTH must be >= 2 and CNT_WIDTH >= 1");
    end

`ifdef LCM_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt;

    modport master (
        output start, mode, A, B,
        input  busy, done, ovf, LCM_out, cycle_cnt
    );

    modport slave (
        input  start, mode, A, B,
        output busy, done, ovf, LCM_out, cycle_cnt
    );
`else
    modport master (
        output start, mode, A, B,
        input  busy, done, ovf, LCM_out
    );

    modport slave (
        input  start, mode, A, B,
        output busy, done, ovf, LCM_out
    );
`endif

endinterface : lcm_gcd_seq_if
`default_nettype wire

// File: rtl/lcm_gcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : lcm_gcd_seq
// Brief    : Iterative LCM/GCD coprocessor, one add/subtract step per clock,
//            with overflow and zero-operand handling. Optional macro
//            LCM_CYCLE_CNT_EN adds a saturating RUN-cycle counter output.
// Revision : 1.0 - initial release
// ============================================================================
module lcm_gcd_seq #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    lcm_gcd_seq_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    if (WIDTH < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("lcm_gcd_seq: WIDTH must be >= 2 and CNT_WIDTH >= 1");
    end

    state_t           r_state;
    logic             r_mode;
    logic [WIDTH:0]   r_x;
    logic [WIDTH:0]   r_y;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

`ifdef LCM_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
`endif

    logic             w_zero;
    logic [WIDTH-1:0] w_zero_res;
    logic             w_x_lt_y;
    logic             w_x_eq_y;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    // x and y stay below 2^WIDTH while running, so the WIDTH+1 bit sum
    // never wraps and its top bit is an exact overflow flag.
    always_comb begin
        w_zero     = (r_sa == '0) || (r_sb == '0);
        w_zero_res = '0;
        if (r_mode) begin
            w_zero_res = (r_sa == '0) ? r_sb : r_sa;
        end
        w_x_lt_y = (r_x < r_y);
        w_x_eq_y = (r_x == r_y);
        w_sum    = w_x_lt_y ? (r_x + {1'b0, r_sa}) : (r_y + {1'b0, r_sb});
        w_diff   = w_x_lt_y ? (r_y - r_x) : (r_x - r_y);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mode   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mode  <= bus.mode;
                        r_x     <= {1'b0, bus.A};
                        r_y     <= {1'b0, bus.B};
                        r_sa    <= bus.A;
                        r_sb    <= bus.B;
                        r_busy  <= 1'b1;
                        r_ovf   <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_zero) begin
                        r_result <= w_zero_res;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_x_eq_y) begin
                        r_result <= r_x[WIDTH-1:0];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else if (!r_mode) begin
                        if (w_sum[WIDTH]) begin
                            r_result <= '0;
                            r_ovf    <= 1'b1;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else if (w_x_lt_y) begin
                            r_x <= w_sum;
                        end else begin
                            r_y <= w_sum;
                        end
                    end else if (w_x_lt_y) begin
                        r_y <= w_diff;
                    end else begin
                        r_x <= w_diff;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LCM_CYCLE_CNT_EN
    // Counts every RUN edge including the finishing one; saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (bus.start) begin
                r_cycle_cnt <= '0;
            end
        end else if (r_cycle_cnt != {CNT_WIDTH{1'b1}}) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`endif

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.ovf     = r_ovf;
    assign bus.LCM_out = r_result;

endmodule : lcm_gcd_seq
`default_nettype wire

// File: tb/tb_lcm_gcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcm_gcd_seq
// Brief    : Directed self-checking bench for lcm_gcd_seq (LCM, GCD, zero
//            operands, overflow, ignored start, reset abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcm_gcd_seq;

    localparam int c_width     = 16;
    localparam int c_cnt_width = 16;
    localparam int c_max_wait  = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lcm_gcd_seq_if #(.WIDTH(c_width), .CNT_WIDTH(c_cnt_width)) bus ();

    lcm_gcd_seq #(.WIDTH(c_width), .CNT_WIDTH(c_cnt_width)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               n_vec = 0;
    int               n_err = 0;
    logic [c_width-1:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat, output bit seen, output bit gap);
        lat  = 0;
        seen = 1'b0;
        gap  = 1'b0;
        while (!seen && lat < c_max_wait) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (!bus.busy) gap = 1'b1;
        end
    endtask

    // Launches one operation, scrambles inputs while busy, checks the result.
    task automatic do_op(input string tag, input logic m, input logic [c_width-1:0] a,
                         input logic [c_width-1:0] b, input logic [c_width-1:0] exp_res,
                         input logic exp_ovf, input int exp_lat);
        int lat;
        bit seen;
        bit gap;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = ~m;
        bus.A     = ~a;
        bus.B     = b ^ 16'h5a5a;
        check({tag, ".busy_e0"}, 32'(bus.busy), 32'd1);
        check({tag, ".done_e0"}, 32'(bus.done), 32'd0);
        check({tag, ".ovf_e0"},  32'(bus.ovf),  32'd0);
        check({tag, ".held_e0"}, 32'(bus.LCM_out), 32'(last_res));
        wait_done(lat, seen, gap);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_gap"}, 32'(gap), 32'd0);
        check({tag, ".result"}, 32'(bus.LCM_out), 32'(exp_res));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
`ifdef LCM_CYCLE_CNT_EN
        check({tag, ".cycle_cnt"}, 32'(bus.cycle_cnt), 32'(exp_lat));
`endif
        last_res = exp_res;
    endtask

    initial begin
        int  lat;
        bit  seen;
        bit  gap;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.A     = 16'd4;
        bus.B     = 16'd6;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.ovf",  32'(bus.ovf),  32'd0);
        check("reset.out",  32'(bus.LCM_out), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;

        do_op("lcm_4_6",    1'b0, 16'd4,     16'd6,     16'd12, 1'b0, 4);
        do_op("lcm_3_5",    1'b0, 16'd3,     16'd5,     16'd15, 1'b0, 7);
        do_op("lcm_1_1",    1'b0, 16'd1,     16'd1,     16'd1,  1'b0, 1);
        do_op("lcm_4_8",    1'b0, 16'd4,     16'd8,     16'd8,  1'b0, 2);
        do_op("gcd_12_18",  1'b1, 16'd12,    16'd18,    16'd6,  1'b0, 3);
        do_op("gcd_0_7",    1'b1, 16'd0,     16'd7,     16'd7,  1'b0, 1);
        do_op("lcm_0_7",    1'b0, 16'd0,     16'd7,     16'd0,  1'b0, 1);
        do_op("gcd_0_0",    1'b1, 16'd0,     16'd0,     16'd0,  1'b0, 1);
        do_op("lcm_ovf",    1'b0, 16'd65535, 16'd65534, 16'd0,  1'b1, 1);
        do_op("lcm_2_3",    1'b0, 16'd2,     16'd3,     16'd6,  1'b0, 4);

        // A start pulse during a run must leave the operation untouched.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.A = 16'd3; bus.B = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.A = 16'd2; bus.B = 16'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, seen, gap);
        check("ignore.latency", 32'(lat + 2), 32'd7);
        check("ignore.result", 32'(bus.LCM_out), 32'd15);
        @(posedge clk); #1;
        check("ignore.single_done", 32'(bus.done), 32'd0);

        // Reset at E3 of a new run aborts it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.A = 16'd3; bus.B = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.out",  32'(bus.LCM_out), 32'd0);
`ifdef LCM_CYCLE_CNT_EN
        check("abort.cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("abort.no_done", 32'(seen), 32'd0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst_n = 1'b0; bus.start = 1'b1; bus.A = 16'd4; bus.B = 16'd6;
        @(posedge clk); #1;
        check("rst_vs_start.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.start = 1'b0;
        last_res = '0;

        do_op("post_reset", 1'b0, 16'd4, 16'd6, 16'd12, 1'b0, 4);
        @(posedge clk); #1;
        check("post_reset.single_done", 32'(bus.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lcm_gcd_seq
`default_nettype wire
